// File: rtl/dilate_window_ctrl_pkg.sv
// Shared types and defaults for the dilation window controller.
// Holds the FSM state enum, default geometry and counter width.
package dilate_window_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam int DEF_WIDTH      = 24;
    localparam int DEF_PIC_WIDTH  = 320;
    localparam int DEF_PIC_HEIGHT = 240;
    localparam int CNT_W          = 9;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/dilate_window_ctrl_if.sv
// Pixel-in / tap-out bundle of the dilation window controller.
// The master drives pixels; the slave (the controller) drives taps and status.
interface dilate_window_ctrl_if
    import dilate_window_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             en;
    logic             sof;
    logic             pix_valid;
    logic [WIDTH-1:0] pix_data;
    logic [WIDTH-1:0] tap_top;
    logic [WIDTH-1:0] tap_mid;
    logic [WIDTH-1:0] tap_bot;
    logic             tap_valid;
    logic             win_valid;
    cnt_t             row_cnt;
    cnt_t             col_cnt;
    logic             frame_done;
    logic             sync_err;

    modport master (
        output en, sof, pix_valid, pix_data,
        input  tap_top, tap_mid, tap_bot, tap_valid, win_valid,
        input  row_cnt, col_cnt, frame_done, sync_err
    );

    modport slave (
        input  en, sof, pix_valid, pix_data,
        output tap_top, tap_mid, tap_bot, tap_valid, win_valid,
        output row_cnt, col_cnt, frame_done, sync_err
    );

endinterface

// File: rtl/dilate_window_ctrl_line_buf.sv
// One video line of storage: synchronous write, asynchronous read.
// Read data is the pre-write word, giving read-before-write per access.
module dilate_window_ctrl_line_buf #(
    parameter int DEPTH = 320,
    parameter int WIDTH = 24,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dilate_window_ctrl.sv
// Raster-scan line-buffer controller feeding a 3x3 dilation window.
// Emits a registered three-row column per accepted pixel once two lines are stored.
module dilate_window_ctrl
    import dilate_window_ctrl_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PIC_WIDTH  = DEF_PIC_WIDTH,
    parameter int PIC_HEIGHT = DEF_PIC_HEIGHT
) (
    input logic                 clk,
    input logic                 rst_n,
    dilate_window_ctrl_if.slave bus
);

    localparam int   AW       = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
    localparam cnt_t LAST_COL = cnt_t'(PIC_WIDTH - 1);
    localparam cnt_t LAST_ROW = cnt_t'(PIC_HEIGHT - 1);

    state_e state_q, state_d;
    cnt_t   row_q, row_d, col_q, col_d;
    cnt_t   row_n, col_n;
    logic   tv_q, tv_d, wv_q, wv_d;
    logic   fd_q, fd_d, err_q, err_d;
    logic   first, accept, last;

    logic [WIDTH-1:0] b0_rd, b1_rd;
    logic [WIDTH-1:0] top_q, mid_q, bot_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        err_d   = err_q;
        tv_d    = 1'b0;
        wv_d    = 1'b0;
        fd_d    = 1'b0;
        row_n   = '0;
        col_n   = '0;
        // sof always names the pixel (0,0), from IDLE or as a resync
        first   = (state_q == IDLE) || bus.sof;
        accept  = bus.en && bus.pix_valid && ((state_q != IDLE) || bus.sof);
        if (!first) begin
            if (col_q == LAST_COL) begin
                row_n = row_q + 1'b1;
            end else begin
                row_n = row_q;
                col_n = col_q + 1'b1;
            end
        end
        last = (row_n == LAST_ROW) && (col_n == LAST_COL);

        if (!bus.en) begin
            state_d = IDLE;
            row_d   = '0;
            col_d   = '0;
        end else if (accept) begin
            row_d = row_n;
            col_d = col_n;
            tv_d  = !first && (row_n >= cnt_t'(2));
            wv_d  = tv_d && (col_n >= cnt_t'(2));
            if (bus.sof && (state_q != IDLE)) begin
                err_d = 1'b1;
            end
            if (first) begin
                state_d = FILL;
            end else if (last) begin
                state_d = IDLE;
                row_d   = '0;
                col_d   = '0;
                fd_d    = 1'b1;
            end else if (tv_d) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            tv_q    <= 1'b0;
            wv_q    <= 1'b0;
            fd_q    <= 1'b0;
            err_q   <= 1'b0;
            top_q   <= '0;
            mid_q   <= '0;
            bot_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            tv_q    <= tv_d;
            wv_q    <= wv_d;
            fd_q    <= fd_d;
            err_q   <= err_d;
            // taps only move on a valid column so they hold through gaps
            if (tv_d) begin
                top_q <= b1_rd;
                mid_q <= b0_rd;
                bot_q <= bus.pix_data;
            end
        end
    end

    dilate_window_ctrl_line_buf #(
        .DEPTH (PIC_WIDTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_buf0 (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (col_n[AW-1:0]),
        .wdata_i (bus.pix_data),
        .rdata_o (b0_rd)
    );

    dilate_window_ctrl_line_buf #(
        .DEPTH (PIC_WIDTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_buf1 (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (col_n[AW-1:0]),
        .wdata_i (b0_rd),
        .rdata_o (b1_rd)
    );

    assign bus.tap_top    = top_q;
    assign bus.tap_mid    = mid_q;
    assign bus.tap_bot    = bot_q;
    assign bus.tap_valid  = tv_q;
    assign bus.win_valid  = wv_q;
    assign bus.row_cnt    = row_q;
    assign bus.col_cnt    = col_q;
    assign bus.frame_done = fd_q;
    assign bus.sync_err   = err_q;

endmodule

// File: tb/tb_dilate_window_ctrl.sv
// Directed bench for dilate_window_ctrl on an 8x6 frame.
// Pixel value is row*16+col so every tap is predictable.
module tb_dilate_window_ctrl;
    import dilate_window_ctrl_pkg::*;

    localparam int W  = 24;
    localparam int PW = 8;
    localparam int PH = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    dilate_window_ctrl_if #(.WIDTH(W)) bus ();

    dilate_window_ctrl #(
        .WIDTH      (W),
        .PIC_WIDTH  (PW),
        .PIC_HEIGHT (PH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] px(input int r, input int c);
        return W'(r * 16 + c);
    endfunction

    task automatic step(input logic en, input logic sof, input logic pv,
                        input logic [W-1:0] d);
        bus.en        = en;
        bus.sof       = sof;
        bus.pix_valid = pv;
        bus.pix_data  = d;
        @(posedge clk);
        #1;
    endtask

    // drives pixels k0..k1 of a frame and tallies what came back
    task automatic run_px(input int k0, input int k1, input bit gap,
                          input bit sof_first, output int ntv, output int nwv,
                          output int nfd, output int nbad);
        logic [W-1:0] ht, hm, hb;
        bit held;
        held = 0;
        ht = '0; hm = '0; hb = '0;
        ntv = 0; nwv = 0; nfd = 0; nbad = 0;
        for (int k = k0; k <= k1; k++) begin
            int r, c, er, ec;
            r  = k / PW;
            c  = k % PW;
            er = (k == PW * PH - 1) ? 0 : r;
            ec = (k == PW * PH - 1) ? 0 : c;
            step(1'b1, sof_first && (k == k0), 1'b1, px(r, c));
            if (bus.tap_valid) ntv++;
            if (bus.win_valid) nwv++;
            if (bus.frame_done) nfd++;
            if (bus.tap_valid !== (r >= 2)) nbad++;
            if (bus.win_valid !== (r >= 2 && c >= 2)) nbad++;
            if (bus.row_cnt !== 9'(er) || bus.col_cnt !== 9'(ec)) nbad++;
            if (r >= 2) begin
                if ({bus.tap_top, bus.tap_mid, bus.tap_bot} !==
                    {px(r - 2, c), px(r - 1, c), px(r, c)}) nbad++;
                ht = px(r - 2, c); hm = px(r - 1, c); hb = px(r, c);
                held = 1;
            end
            if (gap) begin
                step(1'b1, 1'b0, 1'b0, '1);
                if (bus.tap_valid !== 1'b0 || bus.win_valid !== 1'b0) nbad++;
                if (bus.frame_done) nfd++;
                if (held && {bus.tap_top, bus.tap_mid, bus.tap_bot} !== {ht, hm, hb})
                    nbad++;
            end
        end
    endtask

    task automatic test_reset();
        bus.en = 1'b0; bus.sof = 1'b0; bus.pix_valid = 1'b0; bus.pix_data = '0;
        rst_n = 1'b0;
        #12;
        checks++; if (bus.tap_valid !== 1'b0) begin errors++;
            $display("FAIL reset_tap_valid: got %0b want 0", bus.tap_valid); end
        checks++; if (bus.win_valid !== 1'b0) begin errors++;
            $display("FAIL reset_win_valid: got %0b want 0", bus.win_valid); end
        checks++; if (bus.frame_done !== 1'b0) begin errors++;
            $display("FAIL reset_frame_done: got %0b want 0", bus.frame_done); end
        checks++; if (bus.sync_err !== 1'b0) begin errors++;
            $display("FAIL reset_sync_err: got %0b want 0", bus.sync_err); end
        checks++; if (bus.row_cnt !== 9'd0 || bus.col_cnt !== 9'd0) begin errors++;
            $display("FAIL reset_cnt: got %0d,%0d want 0,0", bus.row_cnt, bus.col_cnt); end
        checks++; if ({bus.tap_top, bus.tap_mid, bus.tap_bot} !== '0) begin errors++;
            $display("FAIL reset_taps: got %0h %0h %0h want 0",
                     bus.tap_top, bus.tap_mid, bus.tap_bot); end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic test_full_frame();
        int a, b, c, d, a2, b2, c2, d2;
        run_px(0, 16, 0, 1, a, b, c, d);
        checks++; if (bus.tap_valid !== 1'b1) begin errors++;
            $display("FAIL full_first_valid: got %0b want 1", bus.tap_valid); end
        checks++; if ({bus.tap_top, bus.tap_mid, bus.tap_bot} !==
                      {24'h00, 24'h10, 24'h20}) begin errors++;
            $display("FAIL full_first_taps: got %0h %0h %0h want 0 10 20",
                     bus.tap_top, bus.tap_mid, bus.tap_bot); end
        checks++; if (bus.row_cnt !== 9'd2 || bus.col_cnt !== 9'd0) begin errors++;
            $display("FAIL full_first_pos: got %0d,%0d want 2,0", bus.row_cnt, bus.col_cnt); end
        run_px(17, 47, 0, 0, a2, b2, c2, d2);
        checks++; if (a + a2 !== 32) begin errors++;
            $display("FAIL full_tap_count: got %0d want 32", a + a2); end
        checks++; if (b + b2 !== 24) begin errors++;
            $display("FAIL full_win_count: got %0d want 24", b + b2); end
        checks++; if (c + c2 !== 1) begin errors++;
            $display("FAIL full_done_count: got %0d want 1", c + c2); end
        checks++; if (d + d2 !== 0) begin errors++;
            $display("FAIL full_pixel_errs: got %0d want 0", d + d2); end
        step(1'b1, 1'b0, 1'b0, '0);
        checks++; if (bus.frame_done !== 1'b0 || bus.tap_valid !== 1'b0) begin errors++;
            $display("FAIL full_after: got done=%0b tv=%0b want 0 0",
                     bus.frame_done, bus.tap_valid); end
    endtask

    task automatic test_gaps();
        int a, b, c, d;
        run_px(0, 47, 1, 1, a, b, c, d);
        checks++; if (a !== 32) begin errors++;
            $display("FAIL gap_tap_count: got %0d want 32", a); end
        checks++; if (b !== 24) begin errors++;
            $display("FAIL gap_win_count: got %0d want 24", b); end
        checks++; if (c !== 1) begin errors++;
            $display("FAIL gap_done_count: got %0d want 1", c); end
        checks++; if (d !== 0) begin errors++;
            $display("FAIL gap_pixel_errs: got %0d want 0", d); end
    endtask

    task automatic test_idle_ignore();
        int a, b, c, d, bad;
        bad = 0;
        repeat (10) begin
            step(1'b1, 1'b0, 1'b1, 24'hABCDEF);
            if (bus.row_cnt !== 9'd0 || bus.col_cnt !== 9'd0) bad++;
            if (bus.tap_valid !== 1'b0 || bus.frame_done !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++;
            $display("FAIL idle_ignore: got %0d bad cycles want 0", bad); end
        run_px(0, 47, 0, 1, a, b, c, d);
        checks++; if (a !== 32 || b !== 24) begin errors++;
            $display("FAIL idle_counts: got tv=%0d wv=%0d want 32 24", a, b); end
        checks++; if (c !== 1 || d !== 0) begin errors++;
            $display("FAIL idle_frame: got done=%0d errs=%0d want 1 0", c, d); end
    endtask

    task automatic test_sof_midframe();
        int a, b, c, d, a2, b2, c2, d2;
        run_px(0, 28, 0, 1, a, b, c, d);
        step(1'b1, 1'b1, 1'b1, px(0, 0));
        checks++; if (bus.sync_err !== 1'b1) begin errors++;
            $display("FAIL sof_err: got %0b want 1", bus.sync_err); end
        checks++; if (bus.row_cnt !== 9'd0 || bus.col_cnt !== 9'd0) begin errors++;
            $display("FAIL sof_pos: got %0d,%0d want 0,0", bus.row_cnt, bus.col_cnt); end
        checks++; if (bus.tap_valid !== 1'b0) begin errors++;
            $display("FAIL sof_tv: got %0b want 0", bus.tap_valid); end
        run_px(1, 15, 0, 0, a, b, c, d);
        checks++; if (a !== 0 || d !== 0) begin errors++;
            $display("FAIL sof_fill: got tv=%0d errs=%0d want 0 0", a, d); end
        run_px(16, 16, 0, 0, a, b, c, d);
        checks++; if (bus.tap_valid !== 1'b1 || {bus.tap_top, bus.tap_mid, bus.tap_bot}
                      !== {24'h00, 24'h10, 24'h20}) begin errors++;
            $display("FAIL sof_first_taps: got %0b %0h %0h %0h want 1 0 10 20",
                     bus.tap_valid, bus.tap_top, bus.tap_mid, bus.tap_bot); end
        run_px(17, 47, 0, 0, a2, b2, c2, d2);
        checks++; if (a + a2 !== 32 || c2 !== 1 || d2 !== 0) begin errors++;
            $display("FAIL sof_rest: got tv=%0d done=%0d errs=%0d want 32 1 0",
                     a + a2, c2, d2); end
        checks++; if (bus.sync_err !== 1'b1) begin errors++;
            $display("FAIL sof_sticky: got %0b want 1", bus.sync_err); end
    endtask

    task automatic test_en_low();
        int a, b, c, d, bad;
        run_px(0, 33, 0, 1, a, b, c, d);
        checks++; if (d !== 0) begin errors++;
            $display("FAIL en_pre: got %0d errs want 0", d); end
        step(1'b0, 1'b0, 1'b1, px(4, 2));
        checks++; if (bus.tap_valid !== 1'b0 || bus.row_cnt !== 9'd0 ||
                      bus.col_cnt !== 9'd0) begin errors++;
            $display("FAIL en_drop: got tv=%0b pos=%0d,%0d want 0 0,0",
                     bus.tap_valid, bus.row_cnt, bus.col_cnt); end
        bad = 0;
        repeat (2) begin
            step(1'b0, 1'b0, 1'b1, px(4, 3));
            if (bus.tap_valid !== 1'b0 || bus.col_cnt !== 9'd0) bad++;
        end
        step(1'b1, 1'b0, 1'b1, px(4, 5));
        if (bus.tap_valid !== 1'b0 || bus.col_cnt !== 9'd0) bad++;
        checks++; if (bad !== 0) begin errors++;
            $display("FAIL en_idle: got %0d bad cycles want 0", bad); end
        run_px(0, 47, 0, 1, a, b, c, d);
        checks++; if (a !== 32 || b !== 24 || c !== 1 || d !== 0) begin errors++;
            $display("FAIL en_next_frame: got tv=%0d wv=%0d done=%0d errs=%0d want 32 24 1 0",
                     a, b, c, d); end
    endtask

    task automatic test_reset_midrun();
        int a, b, c, d;
        run_px(0, 27, 0, 1, a, b, c, d);
        checks++; if (bus.tap_valid !== 1'b1) begin errors++;
            $display("FAIL rst_pre_tv: got %0b want 1", bus.tap_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.tap_valid, bus.win_valid, bus.frame_done, bus.sync_err} !== 4'b0)
            begin errors++;
            $display("FAIL rst_flags: got tv=%0b wv=%0b fd=%0b se=%0b want 0",
                     bus.tap_valid, bus.win_valid, bus.frame_done, bus.sync_err); end
        checks++; if (bus.row_cnt !== 9'd0 || bus.col_cnt !== 9'd0) begin errors++;
            $display("FAIL rst_pos: got %0d,%0d want 0,0", bus.row_cnt, bus.col_cnt); end
        checks++; if ({bus.tap_top, bus.tap_mid, bus.tap_bot} !== '0) begin errors++;
            $display("FAIL rst_taps: got %0h %0h %0h want 0",
                     bus.tap_top, bus.tap_mid, bus.tap_bot); end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b1, px(3, 4));
        checks++; if (bus.tap_valid !== 1'b0 || bus.col_cnt !== 9'd0) begin errors++;
            $display("FAIL rst_wait_sof: got tv=%0b col=%0d want 0 0",
                     bus.tap_valid, bus.col_cnt); end
        run_px(0, 47, 0, 1, a, b, c, d);
        checks++; if (a !== 32 || b !== 24 || c !== 1 || d !== 0) begin errors++;
            $display("FAIL rst_recover: got tv=%0d wv=%0d done=%0d errs=%0d want 32 24 1 0",
                     a, b, c, d); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gaps();
        test_idle_ignore();
        test_sof_midframe();
        test_en_low();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dilate_window_ctrl.md
DILATE_WINDOW_CTRL -- requirements
Module: dilate_window_ctrl

Interface
REQ-001 Parameter WIDTH, default 24: pixel width in bits.
REQ-002 Parameter PIC_WIDTH, default 320: pixels per line.
REQ-003 Parameter PIC_HEIGHT, default 240: lines per frame.
REQ-004 clk  input  1  clock; all logic rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  block enable; low forces IDLE.
REQ-007 sof  input  1  start-of-frame pulse, qualified with pix_valid, marks pixel (0,0).
REQ-008 pix_valid  input  1  input pixel strobe.
REQ-009 pix_data  input  WIDTH  input pixel, raster order.
REQ-010 tap_top / tap_mid / tap_bot  output  WIDTH each  column of rows r-2 / r-1 / r, same column.
REQ-011 tap_valid  output  1  taps valid; drives the 3x3 window's valid_in.
REQ-012 win_valid  output  1  full 3x3 window available (row>=2, col>=2 of the accepted pixel).
REQ-013 row_cnt / col_cnt  output  9 each  position of the most recently accepted pixel.
REQ-014 frame_done  output  1  one-cycle pulse after last pixel of frame.
REQ-015 sync_err  output  1  sticky: sof seen mid-frame or pixel outside frame.

Function
REQ-016 FSM states IDLE, FILL, RUN; accept = pix_valid in FILL/RUN, or pix_valid&sof in IDLE.
REQ-017 IDLE: pix_valid without sof ignored (no counter/buffer change); pix_valid&sof&en -> FILL, pixel (0,0) accepted.
REQ-018 col_cnt increments per accepted pixel; at PIC_WIDTH-1 wraps to 0 and row_cnt increments.
REQ-019 FILL -> RUN when row_cnt becomes 2 (first pixel of third line accepted).
REQ-020 Accepting pixel (PIC_HEIGHT-1, PIC_WIDTH-1): frame_done=1 next cycle, state -> IDLE, counters -> 0.
REQ-021 Two line buffers, depth PIC_WIDTH, addressed by col_cnt: per accept, read both at col, write buf0<=pix_data, buf1<=old buf0[col].
REQ-022 Taps registered: one cycle after accept, tap_bot=pix_data, tap_mid=buf0[col] old, tap_top=buf1[col] old.
REQ-023 tap_valid = 1 exactly one cycle after each accept made in RUN (incl. the transition accept), else 0; latency 1 cycle.
REQ-024 win_valid = tap_valid AND accepted col_cnt >= 2.
REQ-025 Taps hold last value when tap_valid=0.
REQ-026 sof with pix_valid in FILL/RUN: sync_err set, frame restarts (counters to (0,0), state FILL); pixel taken as (0,0).
REQ-027 en deasserted in any state: next cycle state IDLE, counters 0, tap_valid=0; buffer contents don't care.
REQ-028 sof and last-pixel never coincide legally; if sof asserted at last pixel, REQ-026 wins, frame_done not pulsed.
REQ-029 sync_err cleared only by reset.
REQ-030 No backpressure: block accepts one pixel per cycle when pix_valid=1.

Reset
REQ-031 rst_n low: state IDLE, row_cnt=col_cnt=0, taps=0, tap_valid=0, win_valid=0, frame_done=0, sync_err=0.
REQ-032 Line-buffer RAM is not reset; first two lines are only written, never presented as valid taps.
REQ-033 Reset mid-frame: after release, block waits for next sof.

Structure
REQ-034 Shared package holds the state enum, default WIDTH/PIC_WIDTH/PIC_HEIGHT and counter width (9).
REQ-035 One sub-module line_buf (single-port read-before-write RAM, depth PIC_WIDTH, width WIDTH), instantiated twice.
REQ-036 Implementation 120-400 lines; no combinational path from pix_data to outputs.

Verification (bench params PIC_WIDTH=8, PIC_HEIGHT=6, WIDTH=24, pixel value = row*16+col)
REQ-037 Full frame contiguous: first tap_valid after accept of (2,0) with top=0x00, mid=0x10, bot=0x20; 48 pixels -> 32 tap_valid, 24 win_valid, one frame_done.
REQ-038 pix_valid toggling 1-0 throughout frame: same tap sequence as REQ-037, tap_valid only after accepts, taps hold in gaps.
REQ-039 pix_valid without sof in IDLE for 10 cycles then sof: no counter change before sof, frame processed normally.
REQ-040 sof at (3,5): sync_err=1, row_cnt=col_cnt=0 next, FILL, no tap_valid for next 16 accepts.
REQ-041 en low at (4,2) for 3 cycles then sof: tap_valid=0 within one cycle, IDLE, clean next frame.
REQ-042 rst_n asserted mid-RUN: all outputs zero asynchronously; recovers on next sof.
